// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard bubble insertion and saturating stall counter.
// Hazard detection and the stall counter exist only when ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              ID_PCSrc,
    input  logic              ID_RegDst,
    input  logic              ID_ALUSrc0,
    input  logic              ID_R_Enable,
    input  logic              ID_W_Enable,
    input  logic              ID_MemToReg,
    input  logic              ID_RegWrite,
    input  logic [1:0]        ID_ALUSrc1,
    input  logic [1:0]        ID_R_Width,
    input  logic [1:0]        ID_W_Width,
    input  logic [3:0]        ID_InstrSel,
    input  logic              ID_ReadsRs,
    input  logic              ID_ReadsRt,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [4:0]        ID_Shamt,
    input  logic [DATA_W-1:0] ID_RsData,
    input  logic [DATA_W-1:0] ID_RtData,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [DATA_W-1:0] ID_PCPlus4,
    output logic              EX_PCSrc,
    output logic              EX_RegDst,
    output logic              EX_ALUSrc0,
    output logic              EX_R_Enable,
    output logic              EX_W_Enable,
    output logic              EX_MemToReg,
    output logic              EX_RegWrite,
    output logic [1:0]        EX_ALUSrc1,
    output logic [1:0]        EX_R_Width,
    output logic [1:0]        EX_W_Width,
    output logic [3:0]        EX_InstrSel,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [4:0]        EX_Shamt,
    output logic [DATA_W-1:0] EX_RsData,
    output logic [DATA_W-1:0] EX_RtData,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [DATA_W-1:0] EX_PCPlus4,
    output logic [4:0]        EX_WriteReg,
    output logic              Stall,
    output logic [CNT_W-1:0]  StallCount
);

    localparam int unsigned REG_W    = 5;
    localparam logic [3:0]  SEL_JAL  = 4'd8;
    localparam logic [REG_W-1:0] REG_RA = REG_W'(31);

    logic             hazard;
    logic [REG_W-1:0] write_reg_d;

    // Destination register of the instruction leaving ID
    always_comb begin
        write_reg_d = ID_Rt;
        if (ID_RegDst) begin
            write_reg_d = ID_Rd;
        end else if (ID_InstrSel == SEL_JAL) begin
            write_reg_d = REG_RA;
        end
    end

`ifdef ID_EX_HAZARD_DETECT_EN
    // Load in EX whose destination is consumed by the instruction in ID
    always_comb begin
        hazard = 1'b0;
        if (EX_R_Enable && EX_RegWrite && (EX_WriteReg != '0)) begin
            hazard = (ID_ReadsRs && (ID_Rs == EX_WriteReg)) ||
                     (ID_ReadsRt && (ID_Rt == EX_WriteReg));
        end
    end

    // Saturating count of hazard bubbles; flush-killed hazards do not count
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end
`else
    logic unused_reads;

    assign hazard       = 1'b0;
    assign StallCount   = '0;
    assign unused_reads = ID_ReadsRs ^ ID_ReadsRt;
`endif

    assign Stall = hazard & ~Flush;

    // EX register: bubble on reset, flush or hazard, otherwise capture ID
    always_ff @(posedge Clk) begin
        if (Reset || Flush || hazard) begin
            EX_PCSrc    <= 1'b0;
            EX_RegDst   <= 1'b0;
            EX_ALUSrc0  <= 1'b0;
            EX_R_Enable <= 1'b0;
            EX_W_Enable <= 1'b0;
            EX_MemToReg <= 1'b0;
            EX_RegWrite <= 1'b0;
            EX_ALUSrc1  <= '0;
            EX_R_Width  <= '0;
            EX_W_Width  <= '0;
            EX_InstrSel <= '0;
            EX_Rs       <= '0;
            EX_Rt       <= '0;
            EX_Rd       <= '0;
            EX_Shamt    <= '0;
            EX_RsData   <= '0;
            EX_RtData   <= '0;
            EX_Imm      <= '0;
            EX_PCPlus4  <= '0;
            EX_WriteReg <= '0;
        end else begin
            EX_PCSrc    <= ID_PCSrc;
            EX_RegDst   <= ID_RegDst;
            EX_ALUSrc0  <= ID_ALUSrc0;
            EX_R_Enable <= ID_R_Enable;
            EX_W_Enable <= ID_W_Enable;
            EX_MemToReg <= ID_MemToReg;
            EX_RegWrite <= ID_RegWrite;
            EX_ALUSrc1  <= ID_ALUSrc1;
            EX_R_Width  <= ID_R_Width;
            EX_W_Width  <= ID_W_Width;
            EX_InstrSel <= ID_InstrSel;
            EX_Rs       <= ID_Rs;
            EX_Rt       <= ID_Rt;
            EX_Rd       <= ID_Rd;
            EX_Shamt    <= ID_Shamt;
            EX_RsData   <= ID_RsData;
            EX_RtData   <= ID_RtData;
            EX_Imm      <= ID_Imm;
            EX_PCPlus4  <= ID_PCPlus4;
            EX_WriteReg <= write_reg_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed load-use scenarios then randomized traffic
// against an instruction-level reference model; a CNT_W=2 instance checks counter saturation.
module tb_id_ex_stage;

    typedef struct packed {
        logic        pcsrc, regdst, alusrc0, r_en, w_en, memtoreg, regwrite;
        logic [1:0]  alusrc1, r_width, w_width;
        logic [3:0]  instrsel;
        logic        reads_rs, reads_rt;
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] rs_data, rt_data, imm, pc4;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst, flush;
    instr_t id;

    // Main instance outputs
    logic        e_pcsrc, e_regdst, e_alusrc0, e_r_en, e_w_en, e_memtoreg, e_regwrite;
    logic [1:0]  e_alusrc1, e_r_width, e_w_width;
    logic [3:0]  e_instrsel;
    logic [4:0]  e_rs, e_rt, e_rd, e_shamt, e_wr;
    logic [31:0] e_rs_data, e_rt_data, e_imm, e_pc4;
    logic        stall;
    logic [15:0] stall_count;

    // Saturation instance outputs
    logic        s_pcsrc, s_regdst, s_alusrc0, s_r_en, s_w_en, s_memtoreg, s_regwrite;
    logic [1:0]  s_alusrc1, s_r_width, s_w_width;
    logic [3:0]  s_instrsel;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt, s_wr;
    logic [31:0] s_rs_data, s_rt_data, s_imm, s_pc4;
    logic        s_stall;
    logic [1:0]  s_count;

    // Reference model state: the instruction believed to sit in EX
    instr_t     ex_m;
    logic [4:0] wr_m;
    int         cnt_m, cnt2_m;
    bit         model_valid = 1'b0;
    int         n_cmp = 0, n_mis = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .Clk(clk), .Reset(rst), .Flush(flush),
        .ID_PCSrc(id.pcsrc), .ID_RegDst(id.regdst), .ID_ALUSrc0(id.alusrc0),
        .ID_R_Enable(id.r_en), .ID_W_Enable(id.w_en), .ID_MemToReg(id.memtoreg),
        .ID_RegWrite(id.regwrite), .ID_ALUSrc1(id.alusrc1), .ID_R_Width(id.r_width),
        .ID_W_Width(id.w_width), .ID_InstrSel(id.instrsel), .ID_ReadsRs(id.reads_rs),
        .ID_ReadsRt(id.reads_rt), .ID_Rs(id.rs), .ID_Rt(id.rt), .ID_Rd(id.rd),
        .ID_Shamt(id.shamt), .ID_RsData(id.rs_data), .ID_RtData(id.rt_data),
        .ID_Imm(id.imm), .ID_PCPlus4(id.pc4),
        .EX_PCSrc(e_pcsrc), .EX_RegDst(e_regdst), .EX_ALUSrc0(e_alusrc0),
        .EX_R_Enable(e_r_en), .EX_W_Enable(e_w_en), .EX_MemToReg(e_memtoreg),
        .EX_RegWrite(e_regwrite), .EX_ALUSrc1(e_alusrc1), .EX_R_Width(e_r_width),
        .EX_W_Width(e_w_width), .EX_InstrSel(e_instrsel), .EX_Rs(e_rs), .EX_Rt(e_rt),
        .EX_Rd(e_rd), .EX_Shamt(e_shamt), .EX_RsData(e_rs_data), .EX_RtData(e_rt_data),
        .EX_Imm(e_imm), .EX_PCPlus4(e_pc4), .EX_WriteReg(e_wr),
        .Stall(stall), .StallCount(stall_count)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .Clk(clk), .Reset(rst), .Flush(flush),
        .ID_PCSrc(id.pcsrc), .ID_RegDst(id.regdst), .ID_ALUSrc0(id.alusrc0),
        .ID_R_Enable(id.r_en), .ID_W_Enable(id.w_en), .ID_MemToReg(id.memtoreg),
        .ID_RegWrite(id.regwrite), .ID_ALUSrc1(id.alusrc1), .ID_R_Width(id.r_width),
        .ID_W_Width(id.w_width), .ID_InstrSel(id.instrsel), .ID_ReadsRs(id.reads_rs),
        .ID_ReadsRt(id.reads_rt), .ID_Rs(id.rs), .ID_Rt(id.rt), .ID_Rd(id.rd),
        .ID_Shamt(id.shamt), .ID_RsData(id.rs_data), .ID_RtData(id.rt_data),
        .ID_Imm(id.imm), .ID_PCPlus4(id.pc4),
        .EX_PCSrc(s_pcsrc), .EX_RegDst(s_regdst), .EX_ALUSrc0(s_alusrc0),
        .EX_R_Enable(s_r_en), .EX_W_Enable(s_w_en), .EX_MemToReg(s_memtoreg),
        .EX_RegWrite(s_regwrite), .EX_ALUSrc1(s_alusrc1), .EX_R_Width(s_r_width),
        .EX_W_Width(s_w_width), .EX_InstrSel(s_instrsel), .EX_Rs(s_rs), .EX_Rt(s_rt),
        .EX_Rd(s_rd), .EX_Shamt(s_shamt), .EX_RsData(s_rs_data), .EX_RtData(s_rt_data),
        .EX_Imm(s_imm), .EX_PCPlus4(s_pc4), .EX_WriteReg(s_wr),
        .Stall(s_stall), .StallCount(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] dest_of(input instr_t i);
        if (i.regdst) return i.rd;
        if (i.instrsel == 4'd8) return 5'd31;
        return i.rt;
    endfunction

    // Load-use: a load in EX writing a nonzero register the ID instruction reads
    function automatic bit model_hazard(input instr_t i);
`ifdef ID_EX_HAZARD_DETECT_EN
        if (!(ex_m.r_en && ex_m.regwrite) || wr_m == 5'd0) return 1'b0;
        return (i.reads_rs && i.rs == wr_m) || (i.reads_rt && i.rt == wr_m);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_ex();
        chk("pcsrc", 32'(e_pcsrc), 32'(ex_m.pcsrc));
        chk("regdst", 32'(e_regdst), 32'(ex_m.regdst));
        chk("alusrc0", 32'(e_alusrc0), 32'(ex_m.alusrc0));
        chk("r_enable", 32'(e_r_en), 32'(ex_m.r_en));
        chk("w_enable", 32'(e_w_en), 32'(ex_m.w_en));
        chk("memtoreg", 32'(e_memtoreg), 32'(ex_m.memtoreg));
        chk("regwrite", 32'(e_regwrite), 32'(ex_m.regwrite));
        chk("alusrc1", 32'(e_alusrc1), 32'(ex_m.alusrc1));
        chk("r_width", 32'(e_r_width), 32'(ex_m.r_width));
        chk("w_width", 32'(e_w_width), 32'(ex_m.w_width));
        chk("instrsel", 32'(e_instrsel), 32'(ex_m.instrsel));
        chk("rs", 32'(e_rs), 32'(ex_m.rs));
        chk("rt", 32'(e_rt), 32'(ex_m.rt));
        chk("rd", 32'(e_rd), 32'(ex_m.rd));
        chk("shamt", 32'(e_shamt), 32'(ex_m.shamt));
        chk("rs_data", e_rs_data, ex_m.rs_data);
        chk("rt_data", e_rt_data, ex_m.rt_data);
        chk("imm", e_imm, ex_m.imm);
        chk("pcplus4", e_pc4, ex_m.pc4);
        chk("write_reg", 32'(e_wr), 32'(wr_m));
        chk("stall_count", 32'(stall_count), 32'(cnt_m));
        chk("sat_count", 32'(s_count), 32'(cnt2_m));
        chk("sat_write_reg", 32'(s_wr), 32'(wr_m));
    endtask

    // One clock: drive ID, check Stall, clock, advance model, check EX
    task automatic cycle(input instr_t i, input bit fl, input bit rs, output bit stalled);
        bit hz;
        id = i; flush = fl; rst = rs;
        #1;
        hz = model_valid ? model_hazard(i) : 1'b0;
        stalled = hz && !fl;
        if (model_valid) chk("stall", 32'(stall), 32'(stalled));
        @(posedge clk); #1;
        if (rs) begin
            ex_m = '0; wr_m = '0; cnt_m = 0; cnt2_m = 0;
        end else begin
            if (stalled) begin
                if (cnt_m < 65535) cnt_m++;
                if (cnt2_m < 3) cnt2_m++;
            end
            if (fl || hz) begin
                ex_m = '0; wr_m = '0;
            end else begin
                ex_m = i; ex_m.reads_rs = 1'b0; ex_m.reads_rt = 1'b0; wr_m = dest_of(i);
            end
        end
        model_valid = 1'b1;
        check_ex();
    endtask

    // Present an instruction until it is accepted (bounded)
    task automatic issue(input instr_t i, input bit fl);
        bit st;
        for (int k = 0; k < 3; k++) begin
            cycle(i, fl, 1'b0, st);
            if (!st) return;
        end
        chk("stall_bound", 32'(st), 32'(0));
    endtask

    function automatic logic [4:0] rand_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd8;
            2: return 5'd9;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i = instr_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        i.rs = rand_reg(); i.rt = rand_reg(); i.rd = rand_reg();
        i.instrsel = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom);
        return i;
    endfunction

    function automatic instr_t lw(input logic [4:0] dst);
        instr_t i = '0;
        i.r_en = 1; i.regwrite = 1; i.memtoreg = 1; i.alusrc1 = 2'd1;
        i.reads_rs = 1; i.rs = 5'd2; i.rt = dst; i.imm = 32'h10; i.pc4 = 32'h400;
        return i;
    endfunction

    function automatic instr_t add(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        instr_t i = '0;
        i.regdst = 1; i.regwrite = 1; i.reads_rs = 1; i.reads_rt = 1;
        i.rs = a; i.rt = b; i.rd = d; i.rs_data = 32'h1234; i.rt_data = 32'h5678;
        i.pc4 = 32'h404;
        return i;
    endfunction

    initial begin
        instr_t i;
        bit st;

        // Reset held two cycles with random ID inputs
        cycle(rand_instr(), 1'b0, 1'b1, st);
        cycle(rand_instr(), 1'($urandom), 1'b1, st);

        // Pass-through addi
        i = '0; i.regwrite = 1; i.alusrc1 = 2'd1; i.reads_rs = 1; i.rs = 5'd1;
        i.rt = 5'd5; i.imm = 32'h0000FFFC;
        issue(i, 1'b0);
        chk("addi_imm", e_imm, 32'h0000FFFC);
        chk("addi_wr", 32'(e_wr), 32'd5);

        // Load-use on rs
        issue(lw(5'd8), 1'b0);
        issue(add(5'd10, 5'd8, 5'd9), 1'b0);

        // $0 never hazards; unread rt never hazards
        issue(lw(5'd0), 1'b0);
        issue(add(5'd11, 5'd0, 5'd0), 1'b0);
        issue(lw(5'd8), 1'b0);
        i = add(5'd12, 5'd3, 5'd8); i.reads_rt = 0;
        issue(i, 1'b0);

        // Flush coincident with hazard
        issue(lw(5'd8), 1'b0);
        cycle(add(5'd13, 5'd8, 5'd8), 1'b1, 1'b0, st);
        issue(add(5'd14, 5'd4, 5'd5), 1'b0);

        // Saturation: reset then four load-use pairs
        cycle(rand_instr(), 1'b0, 1'b1, st);
        for (int n = 0; n < 4; n++) begin
            issue(lw(5'd8), 1'b0);
            issue(add(5'd15, 5'd9, 5'd8), 1'b0);
        end

        // jal destination and random traffic
        i = rand_instr(); i.regdst = 0; i.instrsel = 4'd8;
        issue(i, 1'b0);
        i = rand_instr();
        for (int n = 0; n < 400; n++) begin
            cycle(i, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0), st);
            if (!st) begin
                i = rand_instr();
                if ($urandom_range(0, 1) == 1) begin
                    i.r_en = 1; i.regwrite = 1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and load-use hazard unit sitting directly downstream of the instruction decoder/controller. Each cycle it captures the decoder's control bundle, register-file operands and immediate into the EX stage. It also detects load-use hazards against the instruction currently in EX, inserts a one-cycle bubble, and drives a stall back to the PC and IF/ID register. A saturating stall counter is kept for performance measurement.

## Interface
- `DATA_W`, default 32: operand/immediate width.
- `CNT_W`, default 16: stall counter width.

- `Clk` in 1: clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Flush` in 1: branch/jump resolved taken; kill the instruction entering EX.
- `ID_PCSrc`, `ID_RegDst`, `ID_ALUSrc0`, `ID_R_Enable`, `ID_W_Enable`, `ID_MemToReg`, `ID_RegWrite` in 1 each: decoder control.
- `ID_ALUSrc1` in 2: ALU B-source select.
- `ID_R_Width`, `ID_W_Width` in 2: memory access width (0 word, 1 half, 2 byte).
- `ID_InstrSel` in 4: branch/jump type.
- `ID_ReadsRs`, `ID_ReadsRt` in 1: ID instruction consumes rs / rt.
- `ID_Rs`, `ID_Rt`, `ID_Rd`, `ID_Shamt` in 5: instruction fields.
- `ID_RsData`, `ID_RtData`, `ID_Imm`, `ID_PCPlus4` in DATA_W.
- `EX_*` out, same widths: registered copies of every `ID_*` control/data input above except `ID_ReadsRs`/`ID_ReadsRt`.
- `EX_WriteReg` out 5: destination register. Equals `ID_Rd` when RegDst=1, else 31 when InstrSel=8 (jal), else `ID_Rt`.
- `Stall` out 1: hold PC and IF/ID this cycle (combinational).
- `StallCount` out CNT_W: number of bubbles inserted by hazard.

## Operation
- Hazard condition H (combinational) is true when all of the following hold: `EX_R_Enable` & `EX_RegWrite` & (`EX_WriteReg`≠0), and (`ID_ReadsRs` & `ID_Rs`==`EX_WriteReg`) or (`ID_ReadsRt` & `ID_Rt`==`EX_WriteReg`).
- `Stall` = H & ~`Flush`.
- Next EX contents, in priority order:
  - `Reset`: bubble.
  - `Flush`: bubble.
  - H: bubble.
  - Otherwise: load ID inputs.
- Bubble: all control outputs 0 (including `InstrSel`); data/field outputs 0.
- A bubble has `R_Enable`=0, so H cannot persist beyond one cycle. Every load-use hazard therefore costs exactly one bubble.
- Register $0 never causes a hazard.
- Flush and H together: Flush wins, `Stall`=0, and the counter does not increment (the ID instruction is dead).
- `StallCount` increments on each cycle where `Stall`=1 and `Reset`=0. It saturates at all-ones.

## Timing
- All `EX_*` outputs and `StallCount` are registered and update on the rising edge of `Clk`. Latency from ID to EX is 1 cycle.
- `Stall` is combinational from the ID inputs and current EX registers, valid in the same cycle.
- Reset values: every `EX_*` = 0, `StallCount` = 0. `Stall` = 0 during the reset cycle, because EX holds a bubble after the reset edge.
- Reset asserted mid-stall: the next edge forces a bubble and clears the counter. A pending stall is dropped.
- Upstream must hold ID inputs stable while `Stall`=1. The stalled instruction is re-presented and loaded on the next edge.

## Configuration
- `ID_EX_HAZARD_DETECT_EN` defined: behaviour as above.
- Not defined:
  - H is tied to 0, `Stall` is constant 0 and `StallCount` is constant 0 (its logic is removed).
  - Only `Reset`/`Flush` insert bubbles.
  - Software must schedule a delay slot after loads.

## Test plan
- Reset held 2 cycles with random ID inputs -> all `EX_*`=0, `Stall`=0, `StallCount`=0.
- Pass-through: addi with `ID_Rt`=5, `ID_Imm`=0x0000FFFC, RegWrite=1 -> next cycle `EX_Imm`=0xFFFC, `EX_WriteReg`=5, `Stall`=0.
- Load-use: lw into $8, then add reading rs=$8 -> `Stall`=1 for exactly one cycle and EX holds a bubble. The add enters EX on the following edge and `StallCount`=1.
- Load to $0 followed by a reader of $0, and lw $8 followed by an instruction with `ID_ReadsRt`=0 and rt=8 -> `Stall` stays 0 in both cases.
- Flush asserted in the same cycle as H -> `Stall`=0, EX is a bubble, `StallCount` unchanged.
- Saturation with CNT_W=2: four consecutive load-use pairs -> `StallCount` reads 1,2,3,3.
